// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch with run/pause/clear and lap-hold display freeze; key-to-effect is 3 edges.
// Digits and flags are registered; there is no backpressure, and key presses are edge-detected once per falling edge.
module bcd_stopwatch #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_ss_n,
    input  logic       key_clr_n,
    input  logic       key_lap_n,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       running,
    output logic       held,
    output logic       wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [3:0][3:0] cnt;
    logic [3:0][3:0] disp;
    logic [3:0][3:0] cnt_inc;
    logic [3:0][3:0] shown;
    logic            roll;

    // bit0 = first flop, bit2 = third flop; a press is the 1->0 step between flops 3 and 2
    logic [2:0] ss_q;
    logic [2:0] clr_q;
    logic [2:0] lap_q;
    logic       ss_p;
    logic       clr_p;
    logic       lap_p;

    assign ss_p  = ss_q[2]  & ~ss_q[1];
    assign clr_p = clr_q[2] & ~clr_q[1];
    assign lap_p = lap_q[2] & ~lap_q[1];

    // roll stays high only if every digit was 9, i.e. the count is wrapping to 00.00
    always_comb begin
        cnt_inc = cnt;
        roll    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (roll) begin
                if (cnt[i] >= 4'd9) begin
                    cnt_inc[i] = 4'd0;
                end else begin
                    cnt_inc[i] = cnt[i] + 4'd1;
                    roll       = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_q    <= 3'b111;
            clr_q   <= 3'b111;
            lap_q   <= 3'b111;
            state   <= IDLE;
            presc   <= '0;
            cnt     <= '0;
            disp    <= '0;
            running <= 1'b0;
            held    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            ss_q  <= {ss_q[1:0], key_ss_n};
            clr_q <= {clr_q[1:0], key_clr_n};
            lap_q <= {lap_q[1:0], key_lap_n};
            wrap  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    presc <= '0;
                    held  <= 1'b0;
                    if (ss_p) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (presc == PMAX) begin
                        presc <= '0;
                        cnt   <= cnt_inc;
                        wrap  <= roll;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                    // leaving RUN overrides any same-cycle lap toggle
                    if (ss_p) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                        held    <= 1'b0;
                    end else if (lap_p) begin
                        held <= ~held;
                        if (!held) disp <= cnt;
                    end
                end
                PAUSE: begin
                    held <= 1'b0;
                    if (clr_p) begin
                        state <= IDLE;
                        cnt   <= '0;
                        presc <= '0;
                    end else if (ss_p) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    held    <= 1'b0;
                end
            endcase
        end
    end

    assign shown = held ? disp : cnt;
    assign dig0  = shown[0];
    assign dig1  = shown[1];
    assign dig2  = shown[2];
    assign dig3  = shown[3];

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench: main instance at DIV=10, a second instance at DIV=2 to reach the 99.99 rollover quickly.
module tb_bcd_stopwatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ss_n, clr_n, lap_n, w_ss_n;
    logic [3:0] d0, d1, d2, d3, w0, w1, w2, w3;
    logic       run, hld, wrp, w_run, w_hld, w_wrp;
    logic [15:0] disp, w_disp;
    int nerr = 0;
    int nchk = 0;

    assign disp   = {d3, d2, d1, d0};
    assign w_disp = {w3, w2, w1, w0};

    bcd_stopwatch #(.CLK_HZ(1000), .TICK_HZ(100)) u_dut (
        .clk(clk), .rst_n(rst_n), .key_ss_n(ss_n), .key_clr_n(clr_n), .key_lap_n(lap_n),
        .dig0(d0), .dig1(d1), .dig2(d2), .dig3(d3),
        .running(run), .held(hld), .wrap(wrp)
    );

    bcd_stopwatch #(.CLK_HZ(200), .TICK_HZ(100)) u_wrap (
        .clk(clk), .rst_n(rst_n), .key_ss_n(w_ss_n), .key_clr_n(1'b1), .key_lap_n(1'b1),
        .dig0(w0), .dig1(w1), .dig2(w2), .dig3(w3),
        .running(w_run), .held(w_hld), .wrap(w_wrp)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // key(s) low for one edge, then released; the effect is visible when this returns
    task automatic press(input logic ss, input logic clr, input logic lap);
        ss_n  = ~ss;
        clr_n = ~clr;
        lap_n = ~lap;
        step(1);
        ss_n  = 1'b1;
        clr_n = 1'b1;
        lap_n = 1'b1;
        step(2);
    endtask

    initial begin
        rst_n = 1'b0; ss_n = 1'b1; clr_n = 1'b1; lap_n = 1'b1; w_ss_n = 1'b1;
        step(2);
        chk16("reset_digits", disp, 16'h0000);
        chk1("reset_running", run, 1'b0);
        chk1("reset_held", hld, 1'b0);
        chk1("reset_wrap", wrp, 1'b0);
        chk1("reset_w_held", w_hld, 1'b0);
        rst_n = 1'b1;
        step(1);

        // rollover on the DIV=2 instance: tick every 2 edges after entering RUN
        w_ss_n = 1'b0; step(1); w_ss_n = 1'b1; step(2);
        chk1("w_running", w_run, 1'b1);
        step(19996);
        chk16("w_9998", w_disp, 16'h9998);
        step(2);
        chk16("w_9999", w_disp, 16'h9999);
        chk1("w_no_wrap_9999", w_wrp, 1'b0);
        step(2);
        chk16("w_rollover", w_disp, 16'h0000);
        chk1("w_wrap_pulse", w_wrp, 1'b1);
        step(1);
        chk1("w_wrap_one_cycle", w_wrp, 1'b0);
        chk1("main_still_idle", run, 1'b0);

        // start: RUN after 3 edges, first tick DIV edges later
        ss_n = 1'b0; step(1); ss_n = 1'b1; step(1);
        chk1("start_latency_2", run, 1'b0);
        step(1);
        chk1("start_latency_3", run, 1'b1);
        chk16("start_zero", disp, 16'h0000);
        step(229);
        chk16("run_0022", disp, 16'h0022);
        step(1);
        chk16("run_0023", disp, 16'h0023);

        // pause at prescaler 3, hold, resume: next tick after 7 edges
        press(1'b1, 1'b0, 1'b0);
        chk1("pause_running", run, 1'b0);
        chk16("pause_digits", disp, 16'h0023);
        step(50);
        chk16("pause_frozen", disp, 16'h0023);
        press(1'b1, 1'b0, 1'b0);
        chk1("resume_running", run, 1'b1);
        step(6);
        chk16("resume_pre_tick", disp, 16'h0023);
        step(1);
        chk16("resume_tick", disp, 16'h0024);

        press(1'b0, 1'b1, 1'b0);
        chk1("clr_in_run_running", run, 1'b1);
        chk16("clr_in_run_digits", disp, 16'h0024);

        // lap lands on a tick edge: latched value is the pre-tick count
        step(4);
        press(1'b0, 1'b0, 1'b1);
        chk1("lap_held", hld, 1'b1);
        chk16("lap_latched", disp, 16'h0024);
        step(300);
        chk16("lap_frozen", disp, 16'h0024);
        press(1'b0, 1'b0, 1'b1);
        chk1("lap_release", hld, 1'b0);
        chk16("lap_live", disp, 16'h0055);

        press(1'b1, 1'b0, 1'b1);
        chk1("ss_lap_running", run, 1'b0);
        chk1("ss_lap_held", hld, 1'b0);
        chk16("ss_lap_digits", disp, 16'h0055);
        press(1'b0, 1'b0, 1'b1);
        chk1("lap_in_pause", hld, 1'b0);

        press(1'b1, 1'b1, 1'b0);
        chk1("ss_clr_running", run, 1'b0);
        chk16("ss_clr_digits", disp, 16'h0000);
        step(20);
        chk16("idle_no_count", disp, 16'h0000);

        // key held 100 edges is one press: RUN from edge 3, 97 edges of counting
        ss_n = 1'b0;
        step(100);
        chk1("hold_running", run, 1'b1);
        chk16("hold_0009", disp, 16'h0009);
        ss_n = 1'b1;
        step(3);
        chk1("release_no_press", run, 1'b1);
        chk16("release_0010", disp, 16'h0010);

        ss_n = 1'b0;
        rst_n = 1'b0;
        step(1);
        chk16("midrun_reset_digits", disp, 16'h0000);
        chk1("midrun_reset_running", run, 1'b0);
        chk1("midrun_reset_held", hld, 1'b0);
        chk1("midrun_reset_wrap", wrp, 1'b0);
        rst_n = 1'b1;
        ss_n = 1'b1;
        step(5);
        chk1("post_reset_idle", run, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
